// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/symmetric period counter with shadowed period/duty/mode.
// Optional PWM_POLARITY_EN adds per-channel shadowed output polarity.
module pwm_multi #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      io_en,
   input  logic [WIDTH-1:0]          io_period,
   input  logic [CHANNELS*WIDTH-1:0] io_duty,
   input  logic                      io_mode,
`ifdef PWM_POLARITY_EN
   input  logic [CHANNELS-1:0]       io_polarity,
`endif
   input  logic                      io_load,
   output logic [CHANNELS-1:0]       io_out,
   output logic [WIDTH-1:0]          io_contador,
   output logic                      io_periodDone
);

   typedef enum logic [0:0] {DirUp, DirDown} dir_e;

   logic [WIDTH-1:0]    cnt_q, cnt_d;
   dir_e                dir_q, dir_d;
   logic                pend_q, pend_d;
   logic [WIDTH-1:0]    period_q, period_d;
   logic                mode_q, mode_d;
   logic [WIDTH-1:0]    duty_q [CHANNELS];
   logic [WIDTH-1:0]    duty_d [CHANNELS];
   logic [CHANNELS-1:0] pol_q, pol_d;

   logic             running, boundary, xfer;
   logic [WIDTH-1:0] eff_period;

   assign running = (cnt_q != '0);

   always_comb begin
      boundary = 1'b0;
      if (running) begin
         if (!mode_q) begin
            boundary = (cnt_q == period_q);
         end else begin
            boundary = (period_q == WIDTH'(1)) || (dir_q == DirDown && cnt_q == WIDTH'(1));
         end
      end
   end

   // Idle counts as a boundary so a load while stopped lands on the next edge.
   assign xfer       = (pend_q || io_load) && (!running || boundary);
   assign eff_period = xfer ? io_period : period_q;

   always_comb begin
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      pend_d   = pend_q || io_load;
      period_d = period_q;
      mode_d   = mode_q;
      pol_d    = pol_q;
      for (int i = 0; i < CHANNELS; i++) duty_d[i] = duty_q[i];

      if (xfer) begin
         pend_d   = 1'b0;
         period_d = io_period;
         mode_d   = io_mode;
         for (int i = 0; i < CHANNELS; i++) duty_d[i] = io_duty[i*WIDTH +: WIDTH];
`ifdef PWM_POLARITY_EN
         pol_d    = io_polarity;
`else
         pol_d    = '0;
`endif
      end

      if (!io_en) begin
         cnt_d = '0;
         dir_d = DirUp;
      end else if (!running || xfer) begin
         cnt_d = (eff_period != '0) ? WIDTH'(1) : '0;
         dir_d = DirUp;
      end else if (!mode_q) begin
         cnt_d = (cnt_q == period_q) ? WIDTH'(1) : cnt_q + WIDTH'(1);
      end else if (period_q == WIDTH'(1)) begin
         cnt_d = WIDTH'(1);
      end else if (dir_q == DirUp) begin
         if (cnt_q == period_q) begin
            dir_d = DirDown;
            cnt_d = cnt_q - WIDTH'(1);
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end else begin
         if (cnt_q == WIDTH'(1)) begin
            dir_d = DirUp;
            cnt_d = WIDTH'(2);
         end else begin
            cnt_d = cnt_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q    <= '0;
         dir_q    <= DirUp;
         pend_q   <= 1'b0;
         period_q <= '0;
         mode_q   <= 1'b0;
         pol_q    <= '0;
         for (int i = 0; i < CHANNELS; i++) duty_q[i] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         pol_q    <= pol_d;
         for (int i = 0; i < CHANNELS; i++) duty_q[i] <= duty_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         io_out[i] = running && ((cnt_q <= duty_q[i]) ^ pol_q[i]);
      end
   end

   assign io_contador   = cnt_q;
   assign io_periodDone = boundary;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed + randomized bench for pwm_multi against a phase-index reference model.
module tb_pwm_multi;
   localparam int CH = 4;
   localparam int W  = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          io_en;
   logic [W-1:0]  io_period;
   logic [CH*W-1:0] io_duty;
   logic          io_mode;
   logic [CH-1:0] io_polarity;
   logic          io_load;
   logic [CH-1:0] io_out;
   logic [W-1:0]  io_contador;
   logic          io_periodDone;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: run flag + phase index k since last (re)start.
   bit m_run, m_mode, m_pend;
   int m_k, m_p;
   int m_duty [CH];
   bit [CH-1:0] m_pol;

   always #5 clock = ~clock;

   pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_en        (io_en),
      .io_period    (io_period),
      .io_duty      (io_duty),
      .io_mode      (io_mode),
`ifdef PWM_POLARITY_EN
      .io_polarity  (io_polarity),
`endif
      .io_load      (io_load),
      .io_out       (io_out),
      .io_contador  (io_contador),
      .io_periodDone(io_periodDone)
   );

   function automatic int m_cnt();
      int m;
      if (!m_run) return 0;
      if (m_p == 1) return 1;
      if (!m_mode) return (m_k % m_p) + 1;
      m = m_k % (2*m_p - 2);
      return (m < m_p) ? m + 1 : 2*m_p - 1 - m;
   endfunction

   function automatic bit m_bnd();
      if (!m_run) return 1'b0;
      if (m_p == 1) return 1'b1;
      if (!m_mode) return m_cnt() == m_p;
      return (m_k > 0) && (m_k % (2*m_p - 2) == 0);
   endfunction

   function automatic logic [CH-1:0] m_out();
      logic [CH-1:0] o = '0;
      for (int i = 0; i < CH; i++)
         if (m_run) o[i] = (m_cnt() <= m_duty[i]) ^ m_pol[i];
      return o;
   endfunction

   task automatic model_edge();
      bit b, x;
      b = m_bnd();
      if (!reset) begin
         m_run = 0; m_k = 0; m_p = 0; m_mode = 0; m_pend = 0; m_pol = '0;
         for (int i = 0; i < CH; i++) m_duty[i] = 0;
      end else begin
         x = (m_pend || io_load) && (!m_run || b);
         if (x) begin
            m_p = int'(io_period); m_mode = io_mode; m_pend = 0;
            for (int i = 0; i < CH; i++) m_duty[i] = int'(io_duty[i*W +: W]);
`ifdef PWM_POLARITY_EN
            m_pol = io_polarity;
`endif
         end else if (io_load) m_pend = 1;
         if (!io_en) begin m_run = 0; m_k = 0; end
         else if (!m_run || x) begin m_run = (m_p != 0); m_k = 0; end
         else m_k++;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      chk("cnt", int'(io_contador), m_cnt());
      chk("out", int'(io_out), int'(m_out()));
      chk("done", int'(io_periodDone), int'(m_bnd()));
   endtask

   task automatic wait_cnt(input int v);
      int n = 0;
      while (int'(io_contador) != v && n < 60) begin tick(); n++; end
      if (int'(io_contador) != v) chk("wait_cnt_timeout", int'(io_contador), v);
   endtask

   task automatic set_duty(input int ch, input int v);
      io_duty[ch*W +: W] = W'(v);
   endtask

   initial begin
      int exp_cnt [6];
      int exp_o0 [6];
      exp_cnt = '{1, 2, 3, 4, 5, 1};
      exp_o0  = '{1, 1, 0, 0, 0, 1};
      reset = 0; io_en = 0; io_period = '0; io_duty = '0; io_mode = 0;
      io_polarity = '0; io_load = 0;
      m_run = 0; m_k = 0; m_p = 0; m_mode = 0; m_pend = 0; m_pol = '0;
      for (int i = 0; i < CH; i++) m_duty[i] = 0;
      tick(); tick();
      chk("reset_cnt", int'(io_contador), 0);
      chk("reset_out", int'(io_out), 0);

      // Edge mode P=5
      reset = 1;
      io_period = 5; set_duty(0, 2); set_duty(1, 0); set_duty(2, 7); set_duty(3, 3);
      io_load = 1; tick(); io_load = 0;
      io_en = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("edge_seq_cnt", int'(io_contador), exp_cnt[i]);
         chk("edge_seq_out0", int'(io_out[0]), exp_o0[i]);
         chk("edge_out1_zero", int'(io_out[1]), 0);
         chk("edge_out2_one", int'(io_out[2]), 1);
      end

      // Mid-period load lands at next boundary
      wait_cnt(2);
      set_duty(0, 4); io_load = 1; tick(); io_load = 0;
      for (int i = 0; i < 12; i++) tick();

      // Disable / re-enable
      wait_cnt(3);
      io_en = 0; tick();
      chk("dis_cnt", int'(io_contador), 0);
      chk("dis_out", int'(io_out), 0);
      chk("dis_done", int'(io_periodDone), 0);
      io_en = 1; tick();
      chk("reen_cnt", int'(io_contador), 1);

      // Symmetric P=4
      io_period = 4; set_duty(0, 2); io_mode = 1; io_load = 1; tick(); io_load = 0;
      for (int i = 0; i < 20; i++) tick();

      // Reset mid-operation
      wait_cnt(3);
      reset = 0; tick();
      chk("rst_mid_cnt", int'(io_contador), 0);
      chk("rst_mid_out", int'(io_out), 0);
      reset = 1;

`ifdef PWM_POLARITY_EN
      io_period = 5; set_duty(0, 2); io_mode = 0; io_polarity = 4'b0001;
      io_en = 0; io_load = 1; tick(); io_load = 0; io_en = 1;
      for (int i = 0; i < 10; i++) tick();
      io_en = 0; tick();
      chk("pol_idle_out", int'(io_out), 0);
      io_en = 1;
`endif

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 60) != 0);
         io_en = ($urandom_range(0, 15) != 0);
         io_load = ($urandom_range(0, 7) == 0);
         io_period = W'($urandom_range(0, 9));
         io_mode = 1'($urandom_range(0, 1));
         io_polarity = CH'($urandom);
         for (int c = 0; c < CH; c++) set_duty(c, $urandom_range(0, 11));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
